flow_control_loop_pipe_seq_init: RTL and testbench
==================================================

// Module: flow_control_loop_pipe_seq_init
// PURPOSE
//  Handshake adapter between a parent's ap_start/ap_done/ap_ready block-level protocol and a pipelined loop body.
//  - Passes start into the pipeline.
//  - Generates the per-run ap_loop_init pulse, which reloads loop-carried registers.
//  - Derives the external ready from loop exit.
//  - Holds done until the next start.
//  Instantiated once inside every pipelined-loop sub-module. Pure control logic: two state bits plus combinational glue.
// PARAMETERS
//  none
// PORTS
//  ap_clk             in   1  single clock; all state updates on rising edge
//  ap_rst             in   1  synchronous, active-high reset
//  ap_start           in   1  external start from parent
//  ap_ready           out  1  external ready: loop consumed its inputs (= loop exit)
//  ap_done            out  1  external done
//  ap_start_int       out  1  start forwarded into pipeline (drives iter0 enable)
//  ap_loop_init       out  1  high during first initiation of a loop run
//  ap_ready_int       in   1  pipeline accepted an iteration this cycle
//  ap_loop_exit_ready in   1  loop exit condition taken this cycle
//  ap_loop_exit_done  in   1  loop finished (parent's internal done)
//  ap_continue_int    out  1  continue to parent done logic; constant 1
//  ap_done_int        in   1  parent internal done; accepted for interface compatibility, unused
// BEHAVIOUR
//  Combinational outputs:
//   - ap_start_int = ap_start.
//   - ap_ready = ap_loop_exit_ready.
//   - ap_continue_int = 1'b1 at all times, including during reset.
//   - ap_loop_init = init_r & ap_start.
//   - ap_done = ap_loop_exit_done | done_r (same-cycle done on exit, then held).
//  State init_r (power-up and reset value 1). Per edge, priority order:
//   1. ap_rst -> 1
//   2. ap_loop_exit_done -> 1 (re-arm for next run)
//   3. ap_ready_int -> 0
//   4. otherwise hold
//  State done_r (power-up and reset value 0). Per edge, priority order:
//   1. ap_rst -> 0
//   2. ap_loop_exit_done -> 1
//   3. ap_start -> 0
//   4. otherwise hold
//  Reset values of outputs (ap_rst=1, inputs low):
//   - ap_ready = 0, ap_done = 0, ap_start_int = 0, ap_loop_init = 0.
//   - ap_loop_init rises as soon as ap_start=1 after reset.
//  Latency: zero-cycle combinational path for start, ready and done; one edge for init/done state.
//  Boundaries:
//   - exit_done and ready_int in the same cycle: exit_done wins, so init_r = 1.
//   - exit_done and start in the same cycle: done_r = 1. The done cache clears on the next start cycle that has no exit.
//   - Start deasserted mid-run: ap_loop_init is masked to 0; init_r is unchanged.
//   - Reset mid-run: init_r = 1 and done_r = 0 on the next edge, regardless of other inputs.
//   - Back-to-back runs: exit_done re-arms init_r, so the next run's first initiation sees ap_loop_init = 1.
// STRUCTURE
//  - Single flat module; no sub-modules.
//  - Shared package: nothing required. Optionally a localparam for reset values (INIT_RST = 1'b1, DONE_RST = 1'b0).
//  - Use initial values matching the reset values for simulation power-up.
// TESTING
//  1. Reset, then start=1, ready_int=0:
//     -> loop_init=1, start_int=1, continue_int=1, done=0, ready=0.
//  2. start=1, ready_int=1 for one cycle:
//     -> loop_init=1 that cycle, 0 the following cycle while start stays 1.
//  3. exit_ready=1 and exit_done=1 for one cycle:
//     -> ready=1 and done=1 that cycle.
//     -> Next cycle with start=0, exit_done=0: done stays 1.
//  4. After case 3, raise start=1 for one cycle:
//     -> done=1 during that cycle, done=0 afterwards.
//     -> loop_init=1 (init re-armed).
//  5. Same cycle ready_int=1 and exit_done=1:
//     -> init_r=1, so loop_init=1 when start=1 next cycle.
//  6. Assert ap_rst mid-run (init_r=0, done_r=1):
//     -> after the edge, done=0 and loop_init follows start.
//     -> ap_continue_int stays 1 throughout.

Source files
------------

// File: rtl/flow_control_loop_pipe_seq_init_pkg.sv
// Shared constants for the pipelined-loop handshake adapter.
// Reset and power-up values of the two state bits.
package flow_control_loop_pipe_seq_init_pkg;
  localparam logic INIT_RST = 1'b1;
  localparam logic DONE_RST = 1'b0;
endpackage

// File: rtl/flow_control_loop_pipe_seq_init.sv
// Adapts the parent's ap_start/ap_done/ap_ready protocol to a pipelined loop body.
// Generates the per-run ap_loop_init pulse and holds done until the next start.
module flow_control_loop_pipe_seq_init (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic ap_start,
  output logic ap_ready,
  output logic ap_done,
  output logic ap_start_int,
  output logic ap_loop_init,
  input  logic ap_ready_int,
  input  logic ap_loop_exit_ready,
  input  logic ap_loop_exit_done,
  output logic ap_continue_int,
  input  logic ap_done_int
);
  import flow_control_loop_pipe_seq_init_pkg::*;

  logic init_q = INIT_RST;
  logic done_q = DONE_RST;
  logic init_d;
  logic done_d;
  logic unused_done_int;

  assign unused_done_int = ap_done_int;

  // Loop exit re-arms init for the next run; it outranks an accepted iteration.
  always_comb begin
    init_d = init_q;
    if (ap_loop_exit_done) begin
      init_d = 1'b1;
    end else if (ap_ready_int) begin
      init_d = 1'b0;
    end else begin
      init_d = init_q;
    end
  end

  // Done is cached on exit and released by the next start that has no exit.
  always_comb begin
    done_d = done_q;
    if (ap_loop_exit_done) begin
      done_d = 1'b1;
    end else if (ap_start) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      init_q <= INIT_RST;
      done_q <= DONE_RST;
    end else begin
      init_q <= init_d;
      done_q <= done_d;
    end
  end

  assign ap_start_int    = ap_start;
  assign ap_ready        = ap_loop_exit_ready;
  assign ap_continue_int = 1'b1;
  assign ap_loop_init    = init_q & ap_start;
  assign ap_done         = ap_loop_exit_done | done_q;

endmodule

// File: tb/tb_flow_control_loop_pipe_seq_init.sv
// Scoreboard bench for flow_control_loop_pipe_seq_init: the driver queues
// hand-computed outputs per cycle, the monitor pops and compares at negedge.
module tb_flow_control_loop_pipe_seq_init;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic ap_start = 1'b0;
  logic ap_ready;
  logic ap_done;
  logic ap_start_int;
  logic ap_loop_init;
  logic ap_ready_int = 1'b0;
  logic ap_loop_exit_ready = 1'b0;
  logic ap_loop_exit_done = 1'b0;
  logic ap_continue_int;
  logic ap_done_int = 1'b0;

  // {ready, done, start_int, loop_init, continue_int}
  typedef struct {
    logic [4:0] exp;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   vec_id = 0;

  flow_control_loop_pipe_seq_init dut (
    .ap_clk             (ap_clk),
    .ap_rst             (ap_rst),
    .ap_start           (ap_start),
    .ap_ready           (ap_ready),
    .ap_done            (ap_done),
    .ap_start_int       (ap_start_int),
    .ap_loop_init       (ap_loop_init),
    .ap_ready_int       (ap_ready_int),
    .ap_loop_exit_ready (ap_loop_exit_ready),
    .ap_loop_exit_done  (ap_loop_exit_done),
    .ap_continue_int    (ap_continue_int),
    .ap_done_int        (ap_done_int)
  );

  always #5 ap_clk = ~ap_clk;

  // Drive one cycle of inputs and queue the expected outputs for that cycle.
  task automatic step(input logic rst, input logic start, input logic rdy_int,
                      input logic ex_rdy, input logic ex_done,
                      input logic e_ready, input logic e_done,
                      input logic e_start_int, input logic e_init);
    exp_t e;
    @(posedge ap_clk);
    #1;
    ap_rst             = rst;
    ap_start           = start;
    ap_ready_int       = rdy_int;
    ap_loop_exit_ready = ex_rdy;
    ap_loop_exit_done  = ex_done;
    ap_done_int        = ex_done;
    e.exp = {e_ready, e_done, e_start_int, e_init, 1'b1};
    e.id  = vec_id;
    vec_id++;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        logic [4:0] act;
        e = exp_q.pop_front();
        act = {ap_ready, ap_done, ap_start_int, ap_loop_init, ap_continue_int};
        n_cmp++;
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL vec%0d {ready,done,start_int,loop_init,continue_int}: got %b expected %b",
                   e.id, act, e.exp);
        end
      end
    end
  end

  initial begin
    int guard;
    // Unchecked settling cycle in reset.
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    //    rst  st   ri   exr  exd    rdy  done sti  init
    step(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0); // v0 reset state
    step(1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1); // v1 first start
    step(1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1); // v2 accepted iteration
    step(1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0); // v3 init dropped
    step(1'b0,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0); // v4 exit: ready+done
    step(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0); // v5 done held
    step(1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1); // v6 new start, re-armed
    step(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0); // v7 done cleared, init masked
    step(1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b1); // v8 exit_done+ready_int+start
    step(1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1); // v9 exit won both priorities
    step(1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1); // v10 done cleared by start
    step(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0); // v11 start low
    step(1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0); // v12 init_r stayed 0
    step(1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0); // v13 exit without start
    step(1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0); // v14 clear init, keep done
    step(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0); // v15 init_r=0 done_r=1
    step(1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0); // v16 reset mid-run
    step(1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1); // v17 after reset
    step(1'b1,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0); // v18 reset beats exit
    step(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0); // v19 done_r cleared
    step(1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1); // v20 init_r set
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge ap_clk);
      guard++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
